// File: rtl/avalon_aes_master_if.sv
// ---------------------------------------------------------------------------
// avalon_aes_master_if
// Avalon-MM bus between the AES sequencer (master) and the AES decryption
// slave.
//   AVL_READ / AVL_WRITE  : read / write strobes (never high together)
//   AVL_CS                : chip select, high whenever a strobe is high
//   AVL_BYTE_EN [3:0]     : byte-lane enables
//   AVL_ADDR [3:0]        : word address
//   AVL_WRITEDATA [31:0]  : write data
//   AVL_READDATA [31:0]   : read data, valid in the cycle the read is accepted
//   AVL_WAITREQUEST       : slave stall; a cycle with it low completes a transfer
// ---------------------------------------------------------------------------
interface avalon_aes_master_if;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [3:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA, AVL_WAITREQUEST
  );

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA, AVL_WAITREQUEST
  );
endinterface

// File: rtl/avalon_aes_master.sv
// ---------------------------------------------------------------------------
// avalon_aes_master
// Hardware sequencer for the AES decryption slave. On START it captures KEY
// and MSG_ENC, writes them to slave registers 0-7, sets the start register
// (14), polls done (15), reads the plaintext from 8-11, clears start and
// pulses DONE.
//   CLK, RESET    : clock, synchronous active-high reset
//   START         : request pulse, sampled only while idle
//   KEY, MSG_ENC  : 128-bit key / ciphertext, [127:96] is the lowest register
//   MSG_DEC       : 128-bit plaintext, register 8 lands in [127:96]
//   BUSY          : high from the cycle after acceptance until DONE
//   DONE          : one-cycle completion pulse
//   ERR           : done-poll timeout, valid with DONE, held until next START
//   avl           : Avalon-MM master port
// ---------------------------------------------------------------------------
module avalon_aes_master #(
  parameter int BYTE_SERIAL = 1,
  parameter int START_DELAY = 2,
  parameter int POLL_LIMIT  = 65535
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic [127:0]               KEY,
  input  logic [127:0]               MSG_ENC,
  output logic [127:0]               MSG_DEC,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERR,
  avalon_aes_master_if.master        avl
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_DATA, ST_WR_START, ST_WAIT, ST_POLL, ST_RD_DEC, ST_WR_CLR, ST_FIN
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t        BUS_IDLE_C   = '{rd: 1'b0, wr: 1'b0, be: 4'b0000, addr: 4'd0, wdata: 32'd0};
  localparam logic [15:0] POLL_LIMIT_C = 16'(POLL_LIMIT);
  localparam logic [15:0] DELAY_LAST_C = 16'(START_DELAY - 1);
  localparam logic [3:0]  CTRL_BE_C    = (BYTE_SERIAL != 0) ? 4'b0001 : 4'b1111;

  state_t       state_r, state_next_s;
  logic [2:0]   idx_r, idx_next_s;
  logic [1:0]   lane_r, lane_next_s;
  logic [15:0]  dly_r, dly_next_s;
  logic [15:0]  poll_r, poll_next_s;
  logic         timeout_r, timeout_next_s;
  logic [127:0] key_r, key_next_s;
  logic [127:0] msg_r, msg_next_s;
  logic [127:0] msg_dec_r, dec_next_s;
  logic         err_r, err_next_s;
  logic         busy_r, done_r;
  bus_t         bus_r;
  logic         ack_s;

  // Word i of a 128-bit value, word 0 being the most significant
  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  // Bus drive for a given state; evaluated on next-state values so the bus is registered
  function automatic bus_t bus_for(input state_t st, input logic [2:0] idx, input logic [1:0] lane,
                                   input logic [127:0] key, input logic [127:0] msg);
    bus_t b;
    b = BUS_IDLE_C;
    case (st)
      ST_WR_DATA: begin
        b.wr    = 1'b1;
        b.addr  = {1'b0, idx};
        b.be    = (BYTE_SERIAL != 0) ? (4'b0001 << lane) : 4'b1111;
        b.wdata = idx[2] ? word_sel(msg, idx[1:0]) : word_sel(key, idx[1:0]);
      end
      ST_WR_START: begin
        b.wr    = 1'b1;
        b.addr  = 4'd14;
        b.be    = CTRL_BE_C;
        b.wdata = 32'h0000_0001;
      end
      ST_POLL: begin
        b.rd   = 1'b1;
        b.addr = 4'd15;
        b.be   = 4'b1111;
      end
      ST_RD_DEC: begin
        b.rd   = 1'b1;
        b.addr = {2'b10, idx[1:0]};
        b.be   = 4'b1111;
      end
      ST_WR_CLR: begin
        b.wr    = 1'b1;
        b.addr  = 4'd14;
        b.be    = CTRL_BE_C;
        b.wdata = 32'h0000_0000;
      end
      default: b = BUS_IDLE_C;
    endcase
    return b;
  endfunction

  assign ack_s = ~avl.AVL_WAITREQUEST;

  // Next-state, counter and capture logic of the sequencer
  always_comb begin
    state_next_s   = state_r;
    idx_next_s     = idx_r;
    lane_next_s    = lane_r;
    dly_next_s     = dly_r;
    poll_next_s    = poll_r;
    timeout_next_s = timeout_r;
    key_next_s     = key_r;
    msg_next_s     = msg_r;
    dec_next_s     = msg_dec_r;
    err_next_s     = err_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_next_s   = ST_WR_DATA;
          idx_next_s     = 3'd0;
          lane_next_s    = 2'd0;
          poll_next_s    = 16'd0;
          timeout_next_s = 1'b0;
          key_next_s     = KEY;
          msg_next_s     = MSG_ENC;
          err_next_s     = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        // Lane is the inner counter, address the outer one
        if (ack_s) begin
          if ((BYTE_SERIAL != 0) && (lane_r != 2'd3)) begin
            lane_next_s = lane_r + 2'd1;
          end else begin
            lane_next_s = 2'd0;
            if (idx_r == 3'd7) begin
              idx_next_s   = 3'd0;
              state_next_s = ST_WR_START;
            end else begin
              idx_next_s = idx_r + 3'd1;
            end
          end
        end else begin
          state_next_s = ST_WR_DATA;
        end
      end
      ST_WR_START: begin
        if (ack_s) begin
          dly_next_s = 16'd0;
          if (START_DELAY == 0) begin
            state_next_s = ST_POLL;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_WR_START;
        end
      end
      ST_WAIT: begin
        // Idle gap so a done bit left over from a previous run can clear
        if (dly_r == DELAY_LAST_C) begin
          state_next_s = ST_POLL;
        end else begin
          dly_next_s = dly_r + 16'd1;
        end
      end
      ST_POLL: begin
        if (ack_s) begin
          poll_next_s = poll_r + 16'd1;
          if (avl.AVL_READDATA[0]) begin
            idx_next_s   = 3'd0;
            state_next_s = ST_RD_DEC;
          end else if ((poll_r + 16'd1) == POLL_LIMIT_C) begin
            timeout_next_s = 1'b1;
            state_next_s   = ST_WR_CLR;
          end else begin
            state_next_s = ST_POLL;
          end
        end else begin
          state_next_s = ST_POLL;
        end
      end
      ST_RD_DEC: begin
        if (ack_s) begin
          case (idx_r[1:0])
            2'd0:    dec_next_s[127:96] = avl.AVL_READDATA;
            2'd1:    dec_next_s[95:64]  = avl.AVL_READDATA;
            2'd2:    dec_next_s[63:32]  = avl.AVL_READDATA;
            default: dec_next_s[31:0]   = avl.AVL_READDATA;
          endcase
          if (idx_r[1:0] == 2'd3) begin
            idx_next_s   = 3'd0;
            state_next_s = ST_WR_CLR;
          end else begin
            idx_next_s = idx_r + 3'd1;
          end
        end else begin
          state_next_s = ST_RD_DEC;
        end
      end
      ST_WR_CLR: begin
        if (ack_s) begin
          err_next_s   = timeout_r;
          state_next_s = ST_FIN;
        end else begin
          state_next_s = ST_WR_CLR;
        end
      end
      ST_FIN:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, counters and registered bus/status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      idx_r     <= 3'd0;
      lane_r    <= 2'd0;
      dly_r     <= 16'd0;
      poll_r    <= 16'd0;
      timeout_r <= 1'b0;
      key_r     <= 128'd0;
      msg_r     <= 128'd0;
      msg_dec_r <= 128'd0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bus_r     <= BUS_IDLE_C;
    end else begin
      state_r   <= state_next_s;
      idx_r     <= idx_next_s;
      lane_r    <= lane_next_s;
      dly_r     <= dly_next_s;
      poll_r    <= poll_next_s;
      timeout_r <= timeout_next_s;
      key_r     <= key_next_s;
      msg_r     <= msg_next_s;
      msg_dec_r <= dec_next_s;
      err_r     <= err_next_s;
      busy_r    <= (state_next_s != ST_IDLE) && (state_next_s != ST_FIN);
      done_r    <= (state_next_s == ST_FIN);
      bus_r     <= bus_for(state_next_s, idx_next_s, lane_next_s, key_next_s, msg_next_s);
    end
  end

  assign MSG_DEC           = msg_dec_r;
  assign BUSY              = busy_r;
  assign DONE              = done_r;
  assign ERR               = err_r;
  assign avl.AVL_READ      = bus_r.rd;
  assign avl.AVL_WRITE     = bus_r.wr;
  assign avl.AVL_CS        = bus_r.rd | bus_r.wr;
  assign avl.AVL_BYTE_EN   = bus_r.be;
  assign avl.AVL_ADDR      = bus_r.addr;
  assign avl.AVL_WRITEDATA = bus_r.wdata;

endmodule

// File: tb/tb_avalon_aes_master.sv
// ---------------------------------------------------------------------------
// tb_avalon_aes_master
// Two sequencer instances (byte-serial and full-word, POLL_LIMIT = 4) share
// one behavioural AES slave; 'sel' picks which instance the slave and the
// bus scoreboard follow. Expected bus transfers are queued when a run is
// started and popped as the selected master completes transfers.
// ---------------------------------------------------------------------------
module tb_avalon_aes_master;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RESET;
  logic         START_s, START_p;
  logic [127:0] KEY, MSG_ENC;
  logic [127:0] MSG_DEC_s, MSG_DEC_p;
  logic         BUSY_s, DONE_s, ERR_s, BUSY_p, DONE_p, ERR_p;

  avalon_aes_master_if if_s();
  avalon_aes_master_if if_p();

  avalon_aes_master #(.BYTE_SERIAL(1), .START_DELAY(2), .POLL_LIMIT(4)) dut_s (
    .CLK(CLK), .RESET(RESET), .START(START_s), .KEY(KEY), .MSG_ENC(MSG_ENC),
    .MSG_DEC(MSG_DEC_s), .BUSY(BUSY_s), .DONE(DONE_s), .ERR(ERR_s), .avl(if_s)
  );

  avalon_aes_master #(.BYTE_SERIAL(0), .START_DELAY(2), .POLL_LIMIT(4)) dut_p (
    .CLK(CLK), .RESET(RESET), .START(START_p), .KEY(KEY), .MSG_ENC(MSG_ENC),
    .MSG_DEC(MSG_DEC_p), .BUSY(BUSY_p), .DONE(DONE_p), .ERR(ERR_p), .avl(if_p)
  );

  int tests_run = 0;
  int fail_cnt  = 0;

  // Selected-instance view of bus and status
  logic         sel = 1'b1;
  logic         m_rd, m_wr, m_cs, m_busy, m_done, m_err;
  logic [3:0]   m_be, m_addr;
  logic [31:0]  m_wdata;
  logic [127:0] m_dec;
  always_comb begin
    if (sel) begin
      m_rd = if_s.AVL_READ; m_wr = if_s.AVL_WRITE; m_cs = if_s.AVL_CS;
      m_be = if_s.AVL_BYTE_EN; m_addr = if_s.AVL_ADDR; m_wdata = if_s.AVL_WRITEDATA;
      m_busy = BUSY_s; m_done = DONE_s; m_err = ERR_s; m_dec = MSG_DEC_s;
    end else begin
      m_rd = if_p.AVL_READ; m_wr = if_p.AVL_WRITE; m_cs = if_p.AVL_CS;
      m_be = if_p.AVL_BYTE_EN; m_addr = if_p.AVL_ADDR; m_wdata = if_p.AVL_WRITEDATA;
      m_busy = BUSY_p; m_done = DONE_p; m_err = ERR_p; m_dec = MSG_DEC_p;
    end
  end

  // Behavioural slave: done after polls_to_done polls (0 = never), plaintext from slv_pt
  int           polls_to_done = 3;
  int           poll_seen = 0;
  logic [127:0] slv_pt = FIPS_PT;
  logic         wreq = 1'b0;
  logic [31:0]  rdata;
  always_comb begin
    rdata = 32'h0;
    if (m_rd && m_addr == 4'd15)
      rdata = {31'd0, (polls_to_done != 0) && (poll_seen + 1 >= polls_to_done)};
    else if (m_rd && m_addr == 4'd8)  rdata = slv_pt[127:96];
    else if (m_rd && m_addr == 4'd9)  rdata = slv_pt[95:64];
    else if (m_rd && m_addr == 4'd10) rdata = slv_pt[63:32];
    else if (m_rd && m_addr == 4'd11) rdata = slv_pt[31:0];
  end
  assign if_s.AVL_READDATA = rdata;
  assign if_p.AVL_READDATA = rdata;
  assign if_s.AVL_WAITREQUEST = wreq;
  assign if_p.AVL_WAITREQUEST = wreq;

  always @(posedge CLK) begin
    if (m_wr && !wreq && m_addr == 4'd14 && m_wdata[0]) poll_seen <= 0;
    else if (m_rd && !wreq && m_addr == 4'd15) poll_seen <= poll_seen + 1;
  end

  // Stall injection: 3 wait cycles on the first address-2 write and the address-9 read
  bit stall_en = 1'b0;
  int st2 = 3, st9 = 3;
  always @(posedge CLK) begin
    #1;
    if (!stall_en) begin
      st2 = 3; st9 = 3; wreq = 1'b0;
    end else if (m_wr && m_addr == 4'd2 && st2 > 0) begin
      wreq = 1'b1; st2 = st2 - 1;
    end else if (m_rd && m_addr == 4'd9 && st9 > 0) begin
      wreq = 1'b1; st9 = st9 - 1;
    end else begin
      wreq = 1'b0;
    end
  end

  // Scoreboard consumer: strobe rules, stall hold, and in-order transfer match
  txn_t        exp_q[$];
  txn_t        e;
  bit          mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [41:0] prev_bus = 42'd0;
  logic [41:0] cur_bus;
  always @(negedge CLK) begin
    if (mon_en) begin
      cur_bus = {m_rd, m_wr, m_be, m_addr, m_wdata};
      tests_run++;
      if (m_cs !== (m_rd | m_wr) || (m_rd & m_wr) !== 1'b0) begin
        fail_cnt++;
        $display("FAIL bus_strobes: cs=%b rd=%b wr=%b, want cs=rd|wr and not both", m_cs, m_rd, m_wr);
      end
      if (prev_stall) begin
        tests_run++;
        if (cur_bus !== prev_bus) begin
          fail_cnt++;
          $display("FAIL stall_hold: bus %h, want held %h", cur_bus, prev_bus);
        end
      end
      prev_stall = (m_rd | m_wr) && wreq;
      prev_bus   = cur_bus;
      if ((m_rd | m_wr) && !wreq) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL txn_unexpected: wr=%b addr=%0d be=%b data=%h, want none", m_wr, m_addr, m_be, m_wdata);
        end else begin
          e = exp_q.pop_front();
          if (m_wr !== e.wr || m_addr !== e.addr || m_be !== e.be || (e.wr && m_wdata !== e.data)) begin
            fail_cnt++;
            $display("FAIL txn: got wr=%b addr=%0d be=%b data=%h, want wr=%b addr=%0d be=%b data=%h",
                     m_wr, m_addr, m_be, m_wdata, e.wr, e.addr, e.be, e.data);
          end
        end
      end
    end
  end

  // Queue the transfers a run should produce from the current KEY/MSG_ENC
  task automatic push_expected(input bit s, input int polls, input bit tout);
    txn_t t;
    logic [31:0] w;
    for (int a = 0; a < 8; a++) begin
      w = (a < 4) ? KEY[127 - 32*a -: 32] : MSG_ENC[127 - 32*(a-4) -: 32];
      for (int l = 0; l < (s ? 4 : 1); l++) begin
        t.wr = 1'b1; t.addr = 4'(a); t.be = s ? (4'b0001 << l) : 4'b1111; t.data = w;
        exp_q.push_back(t);
      end
    end
    t.wr = 1'b1; t.addr = 4'd14; t.be = s ? 4'b0001 : 4'b1111; t.data = 32'h1;
    exp_q.push_back(t);
    for (int p = 0; p < (tout ? 4 : polls); p++) begin
      t.wr = 1'b0; t.addr = 4'd15; t.be = 4'b1111; t.data = 32'h0;
      exp_q.push_back(t);
    end
    if (!tout) begin
      for (int a = 8; a < 12; a++) begin
        t.wr = 1'b0; t.addr = 4'(a); t.be = 4'b1111; t.data = 32'h0;
        exp_q.push_back(t);
      end
    end
    t.wr = 1'b1; t.addr = 4'd14; t.be = s ? 4'b0001 : 4'b1111; t.data = 32'h0;
    exp_q.push_back(t);
  endtask

  // Called at a negedge: queue expectations, pulse START over edge 0, then scramble inputs
  task automatic kick(input bit s, input int polls, input bit tout);
    push_expected(s, polls, tout);
    if (s) START_s = 1'b1; else START_p = 1'b1;
    @(posedge CLK);
    #1;
    START_s = 1'b0; START_p = 1'b0;
    KEY = {$urandom, $urandom, $urandom, $urandom};
    MSG_ENC = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Cycle number (edge 0 = acceptance) at which DONE is seen; 0 if it never comes
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      if (m_done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if ({if_s.AVL_READ, if_s.AVL_WRITE, if_s.AVL_CS, BUSY_s, DONE_s, ERR_s} !== 6'b0) begin
      fail_cnt++; $display("FAIL reset_ctrl_s: got %b, want 000000", {if_s.AVL_READ, if_s.AVL_WRITE, if_s.AVL_CS, BUSY_s, DONE_s, ERR_s});
    end
    tests_run++;
    if ({if_p.AVL_READ, if_p.AVL_WRITE, if_p.AVL_CS, BUSY_p, DONE_p, ERR_p} !== 6'b0) begin
      fail_cnt++; $display("FAIL reset_ctrl_p: got %b, want 000000", {if_p.AVL_READ, if_p.AVL_WRITE, if_p.AVL_CS, BUSY_p, DONE_p, ERR_p});
    end
    tests_run++;
    if (MSG_DEC_s !== 128'd0 || MSG_DEC_p !== 128'd0) begin
      fail_cnt++; $display("FAIL reset_msg_dec: got %h / %h, want 0", MSG_DEC_s, MSG_DEC_p);
    end
    RESET = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_run(input string name, input bit s, input int exp_cyc, input logic [127:0] pt);
    int cyc;
    sel = s; polls_to_done = 3; slv_pt = pt; KEY = FIPS_KEY; MSG_ENC = FIPS_CT;
    @(negedge CLK);
    kick(s, 3, 1'b0);
    tests_run++;
    if (m_busy !== 1'b1) begin
      fail_cnt++; $display("FAIL %s_busy: got %b, want 1", name, m_busy);
    end
    wait_done(cyc);
    tests_run++;
    if (cyc != exp_cyc) begin
      fail_cnt++; $display("FAIL %s_done_cycle: got %0d, want %0d", name, cyc, exp_cyc);
    end
    tests_run++;
    if (m_dec !== pt || m_err !== 1'b0 || m_busy !== 1'b0) begin
      fail_cnt++; $display("FAIL %s_result: dec=%h err=%b busy=%b, want dec=%h err=0 busy=0", name, m_dec, m_err, m_busy, pt);
    end
    @(negedge CLK);
    tests_run++;
    if (m_done !== 1'b0 || exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL %s_tail: done=%b pending=%0d, want done=0 pending=0", name, m_done, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int cyc;
    sel = 1'b0; polls_to_done = 0; slv_pt = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    KEY = FIPS_KEY; MSG_ENC = FIPS_CT;
    @(negedge CLK);
    kick(1'b0, 0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (cyc != 17) begin
      fail_cnt++; $display("FAIL timeout_done_cycle: got %0d, want 17", cyc);
    end
    tests_run++;
    if (m_err !== 1'b1 || m_dec !== FIPS_PT) begin
      fail_cnt++; $display("FAIL timeout_result: err=%b dec=%h, want err=1 dec=%h", m_err, m_dec, FIPS_PT);
    end
    repeat (3) @(negedge CLK);
    tests_run++;
    if (m_err !== 1'b1 || exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL timeout_err_hold: err=%b pending=%0d, want err=1 pending=0", m_err, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit pulsed;
    sel = 1'b0; polls_to_done = 3; slv_pt = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    KEY = FIPS_KEY; MSG_ENC = FIPS_CT;
    @(negedge CLK);
    kick(1'b0, 3, 1'b0);
    tests_run++;
    if (m_err !== 1'b0 || m_busy !== 1'b1) begin
      fail_cnt++; $display("FAIL b2b_err_clear: err=%b busy=%b, want err=0 busy=1", m_err, m_busy);
    end
    cyc = 0; pulsed = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      START_p = 1'b0;
      if (m_done === 1'b1) begin cyc = c; break; end
      if (!pulsed && m_rd && m_addr == 4'd15) begin START_p = 1'b1; pulsed = 1'b1; end
    end
    tests_run++;
    if (cyc != 20 || m_dec !== slv_pt) begin
      fail_cnt++; $display("FAIL b2b_first: cycle=%0d dec=%h, want 20 / %h", cyc, m_dec, slv_pt);
    end
    @(negedge CLK);
    tests_run++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      fail_cnt++; $display("FAIL b2b_single_done: done=%b busy=%b, want 0 0", m_done, m_busy);
    end
    slv_pt = FIPS_PT; KEY = FIPS_KEY; MSG_ENC = FIPS_CT;
    kick(1'b0, 3, 1'b0);
    tests_run++;
    if (m_busy !== 1'b1) begin
      fail_cnt++; $display("FAIL b2b_second_accept: busy=%b, want 1", m_busy);
    end
    wait_done(cyc);
    tests_run++;
    if (cyc != 20 || m_dec !== FIPS_PT || m_err !== 1'b0) begin
      fail_cnt++; $display("FAIL b2b_second: cycle=%0d dec=%h err=%b, want 20 / %h / 0", cyc, m_dec, m_err, FIPS_PT);
    end
    @(negedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL b2b_pending: got %0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    sel = 1'b1; polls_to_done = 3; slv_pt = FIPS_PT; KEY = FIPS_KEY; MSG_ENC = FIPS_CT;
    @(negedge CLK);
    kick(1'b1, 3, 1'b0);
    hit = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      if (m_wr && m_addr == 4'd5) begin hit = 1'b1; break; end
    end
    tests_run++;
    if (!hit) begin
      fail_cnt++; $display("FAIL rst_mid_reach: addr 5 write seen=0, want 1");
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    exp_q.delete();
    @(negedge CLK);
    tests_run++;
    if ({m_rd, m_wr, m_cs, m_busy} !== 4'b0 || m_dec !== 128'd0) begin
      fail_cnt++; $display("FAIL rst_mid_state: rd/wr/cs/busy=%b dec=%h, want 0000 / 0", {m_rd, m_wr, m_cs, m_busy}, m_dec);
    end
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START_s = 1'b0; START_p = 1'b0;
    KEY = FIPS_KEY; MSG_ENC = FIPS_CT;
    test_reset();
    test_run("serial", 1'b1, 44, FIPS_PT);
    test_run("parallel", 1'b0, 20, FIPS_PT);
    test_timeout();
    test_back_to_back();
    stall_en = 1'b1;
    test_run("stall", 1'b1, 50, FIPS_PT);
    stall_en = 1'b0;
    test_reset_mid();
    test_run("after_reset", 1'b1, 44, FIPS_PT);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
